// File: rtl/moore_sequence_generator.sv
// rtl/moore_sequence_generator.sv - serial pattern transmitter feeding a sequence detector's din
//
// Purpose:
//   Latches a PAT_W-bit pattern and shifts out its low len bits MSB-first,
//   one bit per clock. The pattern is sent rep times. GAP_CYCLES idle cycles
//   can be inserted between copies. All outputs come straight from flops, so
//   dout can drive a detector's din directly.
//
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high
//   start       in   1      transfer request, honoured only in IDLE
//   pattern_in  in   PAT_W  pattern; bits [len-1:0] are sent, bit len-1 first
//   len_in      in   LEN_W  bits per copy; 0 ignores the request, >PAT_W clamps
//   rep_in      in   REP_W  number of copies; 0 behaves as 1
//   abort       in   1      cancels a running transfer (SHIFT or GAP)
//   dout        out  1      serial data, IDLE_LEVEL when not valid
//   dout_valid  out  1      dout carries a pattern bit
//   busy        out  1      high in SHIFT and GAP
//   done        out  1      one-cycle pulse after the last bit of the last copy

module moore_sequence_generator #(
  parameter int PAT_W      = 8,
  parameter int LEN_W      = 4,
  parameter int REP_W      = 4,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [REP_W-1:0] rep_in,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  // Copies still to send after the one currently on the wire.
  logic [REP_W-1:0] rep_left_q, rep_left_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic dout_d, dout_valid_d, busy_d, done_d;

  logic [LEN_W-1:0] len_clamped;
  logic [IDX_W-1:0] top_idx_in;
  logic [IDX_W-1:0] top_idx_q;
  logic             accept;

  assign len_clamped = (len_in > LEN_MAX) ? LEN_MAX : len_in;
  // len is never 0 when these are used, so len-1 cannot underflow and fits IDX_W.
  assign top_idx_in  = IDX_W'(len_clamped - 1'b1);
  assign top_idx_q   = IDX_W'(len_q - 1'b1);
  assign accept      = start && (len_in != '0);

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      rep_left_q <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      dout       <= IDLE_LEVEL;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      rep_left_q <= rep_left_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next state and datapath update.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    rep_left_d = rep_left_q;
    idx_d      = idx_q;
    gap_d      = gap_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_SHIFT;
          pat_d      = pattern_in;
          len_d      = len_clamped;
          rep_left_d = (rep_in == '0) ? '0 : rep_in - 1'b1;
          idx_d      = top_idx_in;
          gap_d      = '0;
        end
      end

      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else if (rep_left_q != '0) begin
          rep_left_d = rep_left_q - 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
          end else begin
            // Back-to-back copies: reload the index so bit len-1 follows bit 0 directly.
            idx_d = top_idx_q;
          end
        end else begin
          state_d = S_DONE;
        end
      end

      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          state_d = S_SHIFT;
          idx_d   = top_idx_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state/datapath and then registered,
  // so they change on the same edge the state does and never glitch.
  always_comb begin
    dout_d       = IDLE_LEVEL;
    dout_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (state_d)
      S_SHIFT: begin
        dout_d       = pat_d[idx_d];
        dout_valid_d = 1'b1;
        busy_d       = 1'b1;
      end
      S_GAP: begin
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        dout_d = IDLE_LEVEL;
      end
    endcase
  end

endmodule

// File: tb/tb_moore_sequence_generator.sv
// tb/tb_moore_sequence_generator.sv - scoreboard bench for moore_sequence_generator
//
// Purpose:
//   Two instances: u_dut0 (GAP_CYCLES=0, IDLE_LEVEL=0) and u_dut2
//   (GAP_CYCLES=2, IDLE_LEVEL=1). Stimulus pushes the expected per-cycle
//   {dout, dout_valid, busy, done} into a queue per instance; a monitor per
//   instance pops and compares on each falling edge.
//
// Ports: none.

module tb_moore_sequence_generator;

  logic       clk = 1'b0;
  logic       reset;

  logic       st0, ab0, st2, ab2;
  logic [7:0] pat0, pat2;
  logic [3:0] len0, rep0, len2, rep2;
  logic       dout0, val0, busy0, done0;
  logic       dout2, val2, busy2, done2;

  logic [3:0] q0[$];
  logic [3:0] q2[$];

  int checks = 0;
  int errors = 0;
  int cyc0   = 0;
  int cyc2   = 0;

  logic [3:0] hist0   = 4'b0000;
  int         det_cnt = 0;
  int         det_snap;

  always #5 clk = ~clk;

  moore_sequence_generator #(
    .PAT_W(8), .LEN_W(4), .REP_W(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .start(st0), .pattern_in(pat0), .len_in(len0),
    .rep_in(rep0), .abort(ab0), .dout(dout0), .dout_valid(val0), .busy(busy0),
    .done(done0)
  );

  moore_sequence_generator #(
    .PAT_W(8), .LEN_W(4), .REP_W(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)
  ) u_dut2 (
    .clk(clk), .reset(reset), .start(st2), .pattern_in(pat2), .len_in(len2),
    .rep_in(rep2), .abort(ab2), .dout(dout2), .dout_valid(val2), .busy(busy2),
    .done(done2)
  );

  // Monitors: one comparison per expected cycle record.
  always @(negedge clk) begin
    logic [3:0] e;
    logic [3:0] a;
    cyc0++;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      a = {dout0, val0, busy0, done0};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL dut0 cycle %0d: dout/valid/busy/done got %b, expected %b", cyc0, a, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    logic [3:0] a;
    cyc2++;
    if (q2.size() != 0) begin
      e = q2.pop_front();
      a = {dout2, val2, busy2, done2};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL dut2 cycle %0d: dout/valid/busy/done got %b, expected %b", cyc2, a, e);
      end
    end
  end

  // Overlapping 1101 detector listening to dut0's serial line every cycle.
  always @(negedge clk) begin
    hist0 = {hist0[2:0], dout0};
    if (hist0 == 4'b1101) det_cnt++;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input bit sel, input logic [3:0] r);
    if (sel) q2.push_back(r);
    else     q0.push_back(r);
  endtask

  task automatic push_idle(input bit sel, input logic idl, input int n);
    for (int i = 0; i < n; i++) push(sel, {idl, 3'b000});
  endtask

  // Expected trace of a whole transfer, followed by the done cycle.
  task automatic push_xfer(input bit sel, input logic [7:0] pat, input int len,
                           input int rep, input int gap, input logic idl);
    for (int c = 0; c < rep; c++) begin
      for (int i = len - 1; i >= 0; i--) push(sel, {pat[i], 3'b110});
      if (c < rep - 1)
        for (int g = 0; g < gap; g++) push(sel, {idl, 3'b010});
    end
    push(sel, {idl, 3'b001});
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q2.size() != 0) && n < 400) begin
      cyc();
      n++;
    end
    checks++;
    if (q0.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain timeout: records left q0=%0d q2=%0d, expected 0", q0.size(), q2.size());
      q0.delete();
      q2.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    st0 = 1'b0; ab0 = 1'b0; pat0 = 8'h00; len0 = 4'd0; rep0 = 4'd0;
    st2 = 1'b0; ab2 = 1'b0; pat2 = 8'h00; len2 = 4'd0; rep2 = 4'd0;

    // Reset values.
    cyc(); cyc();
    q0.push_back(4'b0000);
    q2.push_back(4'b1000);
    cyc();
    reset = 1'b0;
    push_idle(0, 1'b0, 2);
    push_idle(1, 1'b1, 2);
    drain();

    // Pattern 1101, one copy: bits 1,1,0,1 then done, then idle.
    cyc();
    pat0 = 8'b0000_1101; len0 = 4'd4; rep0 = 4'd1; st0 = 1'b1;
    push(0, 4'b1110); push(0, 4'b1110); push(0, 4'b0110); push(0, 4'b1110);
    push(0, 4'b0001); push(0, 4'b0000); push(0, 4'b0000);
    cyc();
    st0 = 1'b0;
    drain();

    // Two copies back-to-back: 11011101, detector sees two hits.
    det_snap = det_cnt;
    cyc();
    pat0 = 8'b0000_1101; len0 = 4'd4; rep0 = 4'd2; st0 = 1'b1;
    push_xfer(0, 8'b0000_1101, 4, 2, 0, 1'b0);
    push_idle(0, 1'b0, 2);
    cyc();
    st0 = 1'b0;
    drain();
    checks++;
    if (det_cnt - det_snap != 2) begin
      errors++;
      $display("FAIL detector hits: got %0d, expected 2", det_cnt - det_snap);
    end

    // len_in=0 is ignored.
    cyc();
    pat0 = 8'hFF; len0 = 4'd0; rep0 = 4'd1; st0 = 1'b1;
    push_idle(0, 1'b0, 3);
    cyc();
    st0 = 1'b0;
    drain();

    // len_in=12 clamps to 8 bits: 10100101.
    cyc();
    pat0 = 8'hA5; len0 = 4'd12; rep0 = 4'd1; st0 = 1'b1;
    push(0, 4'b1110); push(0, 4'b0110); push(0, 4'b1110); push(0, 4'b0110);
    push(0, 4'b0110); push(0, 4'b1110); push(0, 4'b0110); push(0, 4'b1110);
    push(0, 4'b0001); push(0, 4'b0000);
    cyc();
    st0 = 1'b0;
    drain();

    // Start while busy and start during DONE are both ignored.
    cyc();
    pat0 = 8'hB2; len0 = 4'd8; rep0 = 4'd1; st0 = 1'b1;
    push_xfer(0, 8'hB2, 8, 1, 0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 1) st0 = 1'b0;
      if (k == 3) begin pat0 = 8'hFF; len0 = 4'd3; st0 = 1'b1; end
      if (k == 4) st0 = 1'b0;
      if (k == 9) begin st0 = 1'b1; push_idle(0, 1'b0, 3); end
    end
    cyc();
    st0 = 1'b0;
    drain();

    // Abort while bit 2 of the first copy is on the wire: IDLE, no done.
    cyc();
    pat0 = 8'b0000_1101; len0 = 4'd4; rep0 = 4'd2; st0 = 1'b1;
    push(0, 4'b1110); push(0, 4'b1110);
    push_idle(0, 1'b0, 3);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k == 1) st0 = 1'b0;
      if (k == 2) ab0 = 1'b1;
      if (k == 3) ab0 = 1'b0;
    end
    drain();

    // Clean transfer after the abort: 0110.
    cyc();
    pat0 = 8'b0000_0110; len0 = 4'd4; rep0 = 4'd1; st0 = 1'b1;
    push(0, 4'b0110); push(0, 4'b1110); push(0, 4'b1110); push(0, 4'b0110);
    push(0, 4'b0001); push(0, 4'b0000);
    cyc();
    st0 = 1'b0;
    drain();

    // Gap instance: 101 x3 with two idle-level gap cycles, 13 busy cycles.
    cyc();
    pat2 = 8'b0000_0101; len2 = 4'd3; rep2 = 4'd3; st2 = 1'b1;
    push(1, 4'b1110); push(1, 4'b0110); push(1, 4'b1110);
    push(1, 4'b1010); push(1, 4'b1010);
    push(1, 4'b1110); push(1, 4'b0110); push(1, 4'b1110);
    push(1, 4'b1010); push(1, 4'b1010);
    push(1, 4'b1110); push(1, 4'b0110); push(1, 4'b1110);
    push(1, 4'b1001); push(1, 4'b1000);
    cyc();
    st2 = 1'b0;
    drain();

    // Reset in the first gap cycle: outputs return to reset values.
    cyc();
    pat2 = 8'b0000_0101; len2 = 4'd3; rep2 = 4'd3; st2 = 1'b1;
    push(1, 4'b1110); push(1, 4'b0110); push(1, 4'b1110); push(1, 4'b1010);
    push_idle(1, 1'b1, 4);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 1) st2 = 1'b0;
      if (k == 4) reset = 1'b1;
      if (k == 5) reset = 1'b0;
    end
    drain();

    // Clean transfer after reset, with len=1 and rep_in=0 treated as one copy.
    cyc();
    pat2 = 8'b0000_0001; len2 = 4'd1; rep2 = 4'd0; st2 = 1'b1;
    push(1, 4'b1110); push(1, 4'b1001); push(1, 4'b1000);
    cyc();
    st2 = 1'b0;
    drain();

    // Two copies of 10 with gap, to check the gap re-entry after a reset.
    cyc();
    pat2 = 8'b0000_0010; len2 = 4'd2; rep2 = 4'd2; st2 = 1'b1;
    push_xfer(1, 8'b0000_0010, 2, 2, 2, 1'b1);
    push_idle(1, 1'b1, 1);
    cyc();
    st2 = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
